ram_dp_clr: RTL and testbench
=============================

Name: ram_dp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one independent read port, both on a single clock.
- Successor to the 8-bit 256-entry single-port program/data RAM.
- Adds separate read and write addresses, a configurable read latency, a selectable read-during-write policy, read-valid signalling, and a hardware clear sequencer run after reset.
- Serves as data memory and register-file backing store for the processor datapath.

Parameters:
- DATA_W, 8: word width in bits.
- DEPTH, 256: number of words; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH): address width; derived, never overridden.
- READ_LATENCY, 1: cycles from rden sampled to q valid; legal values 1 or 2.
- RDW_MODE, 0: same-address read-during-write result; 0 = old data, 1 = new (written) data.
- INIT_VALUE, 0: DATA_W-bit value written to every word by the clear sequencer.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wren  input  1  write enable.
- wr_address  input  ADDR_W  write address.
- data  input  DATA_W  write data.
- rden  input  1  read enable.
- rd_address  input  ADDR_W  read address.
- q  output  DATA_W  read data; registered.
- q_valid  output  1  one-cycle pulse, aligned with q, for each accepted read.
- busy  output  1  clear sequencer active; all requests ignored.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clock, reset port is reset.
- Reset, at a posedge with reset=1:
  - state <= CLEAR, clr_cnt <= 0, busy <= 1.
  - q <= 0, q_valid <= 0, read pipeline flushed.
  - Memory contents are not touched on the reset edge itself.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle mem[clr_cnt] <= INIT_VALUE and clr_cnt increments. At clr_cnt == DEPTH-1 the final word is written, state <= IDLE and busy <= 0 on that same edge.
  - busy is therefore high for exactly DEPTH cycles after the first cycle with reset low.
  - IDLE: normal operation. The only exit is reset.
- While busy=1: wren and rden are ignored, no memory write or read occurs, q holds 0, q_valid=0.
- Write: in IDLE with wren=1, mem[wr_address] <= data at the posedge.
- Read: in IDLE with rden=1, rd_address is sampled at posedge T.
  - READ_LATENCY=1: q and q_valid=1 update at edge T.
  - READ_LATENCY=2: q and q_valid=1 update at edge T+1.
  - Back-to-back reads are fully pipelined: one result per cycle.
- q_valid is 0 in every cycle without a matching read. q holds its last value when no read completes.
- Read-during-write, wren=rden=1 with equal addresses in the same cycle:
  - RDW_MODE=0: q returns the pre-write contents.
  - RDW_MODE=1: q returns data (bypass).
  - Memory is written in both modes.
- Different read and write addresses in the same cycle are fully independent.
- Reset mid-operation, including mid-CLEAR or with a read in the pipeline:
  - In-flight reads are discarded and q_valid is never asserted for them.
  - The clear restarts from address 0.
  - Words written before the reset are overwritten by the clear.
- Reset held for several cycles: remains in CLEAR with clr_cnt=0 and busy=1. No clear writes occur until reset deasserts.
- Address wrap: not possible, since DEPTH = 2**ADDR_W. clr_cnt is ADDR_W+1 bits wide, or equivalent, so the DEPTH-1 terminal is detected without overflow ambiguity.
- No X on q or q_valid at any time after the first reset edge.

Test Plan:
- Clear: defaults with INIT_VALUE=8'hA5. Pulse reset for 1 cycle. busy must be high for exactly 256 cycles, then low. Reading addresses 0, 127 and 255 returns 8'hA5 with q_valid one cycle after rden.
- Write/read latency, READ_LATENCY=1: write 8'h3C to address 8'h10, then read 8'h10 on the next cycle. q=8'h3C and q_valid=1 on the following edge; q_valid=0 on the next cycle when rden=0.
- Latency 2 streaming: READ_LATENCY=2, with addresses 0..3 preloaded with 8'h11, 8'h22, 8'h33, 8'h44. Issue four back-to-back reads. q_valid is high for 4 consecutive cycles starting 2 edges after the first rden, and q returns 11, 22, 33, 44 in order.
- Read-during-write: address 8'h20 holds 8'h55. In one cycle write 8'hAA to 8'h20 and read 8'h20. RDW_MODE=0 gives q=8'h55; RDW_MODE=1 gives q=8'hAA. A subsequent read returns 8'hAA in both modes.
- Busy lockout: during CLEAR assert wren to address 8'hFF with 8'h77, and assert rden. No q_valid pulse occurs. After busy drops, address 8'hFF reads INIT_VALUE.
- Reset mid-operation: issue a read with READ_LATENCY=2 and assert reset on the next cycle. No q_valid pulse occurs, q=0, busy is high again for 256 cycles, and previously written 8'h3C at 8'h10 reads back as INIT_VALUE.

Source files
------------

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple-dual-port synchronous RAM with one write port and one
// read port on a single clock. It has a configurable read latency (1 or 2)
// and a selectable same-address read-during-write result. After every reset,
// a clear sequencer writes INIT_VALUE to every word.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   wren       write enable            wr_address  write address
//   data       write data
//   rden       read enable             rd_address  read address
//   q          registered read data; holds its value between reads
//   q_valid    one-cycle pulse aligned with q for each accepted read
//   busy       clear sequencer active; wren/rden are ignored
module ram_dp_clr #(
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 256,
  parameter int                ADDR_W       = $clog2(DEPTH),
  parameter int                READ_LATENCY = 1,
  parameter int                RDW_MODE     = 0,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] data,
  input  logic              rden,
  input  logic [ADDR_W-1:0] rd_address,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  typedef enum logic {CLEAR, IDLE} state_e;

  // The counter is one bit wider than the address, so the terminal value
  // DEPTH-1 is unambiguous and the counter never wraps back into range.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH-1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
        if (clr_cnt_q == CLR_LAST) state_d = IDLE;
      end
      default: ;
    endcase
  end

  assign busy = (state_q == CLEAR);

  // The single memory write port is shared by the clear sequencer and the
  // user write. The reset edge itself leaves the memory untouched.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign mem_we = !reset && (busy || wren);
  assign mem_wa = busy ? clr_cnt_q[ADDR_W-1:0] : wr_address;
  assign mem_wd = busy ? INIT_VALUE : data;

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read side. In old-data mode, the array read before the write lands
  // returns the pre-write word. In new-data mode, a same-address write
  // bypasses the array.
  logic              rd_acc;
  logic              rdw_hit;
  logic [DATA_W-1:0] rd_data;

  assign rd_acc  = !reset && !busy && rden;
  assign rdw_hit = wren && (wr_address == rd_address);
  assign rd_data = (RDW_MODE != 0 && rdw_hit) ? data : mem[rd_address];

  // Stage 1 captures the array read at the rden edge. A second stage is
  // present only when READ_LATENCY == 2. Data stages load only with a valid
  // read, so q holds its last value between reads.
  logic [READ_LATENCY:1]             vld_pipe_q;
  logic [READ_LATENCY:1][DATA_W-1:0] data_pipe_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= rd_acc;
      if (rd_acc) data_pipe_q[1] <= rd_data;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        if (vld_pipe_q[k-1]) data_pipe_q[k] <= data_pipe_q[k-1];
      end
    end
  end

  assign q       = data_pipe_q[READ_LATENCY];
  assign q_valid = vld_pipe_q[READ_LATENCY];

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr. It drives two instances with the same stimulus:
//   dut0: READ_LATENCY=1, RDW_MODE=0 (old data)
//   dut1: READ_LATENCY=2, RDW_MODE=1 (new data)
// Both use INIT_VALUE=8'hA5. Each instance has a reference model: a memory
// array, a busy countdown, and a read-result schedule keyed by edge number.
module tb_ram_dp_clr;

  localparam logic [7:0] INIT = 8'hA5;
  localparam int         DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst, wren, rden;
  logic [7:0] wa, wd, ra;
  logic [7:0] q_w [2];
  logic       qv_w [2];
  logic       busy_w [2];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_dp_clr #(.DATA_W(8), .DEPTH(DEPTH), .READ_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(INIT)) dut0 (
    .clock(clk), .reset(rst), .wren(wren), .wr_address(wa), .data(wd),
    .rden(rden), .rd_address(ra), .q(q_w[0]), .q_valid(qv_w[0]), .busy(busy_w[0]));

  ram_dp_clr #(.DATA_W(8), .DEPTH(DEPTH), .READ_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(INIT)) dut1 (
    .clock(clk), .reset(rst), .wren(wren), .wr_address(wa), .data(wd),
    .rden(rden), .rd_address(ra), .q(q_w[1]), .q_valid(qv_w[1]), .busy(busy_w[1]));

  // ---------------- reference model ----------------
  // Instance i has latency i+1, and new-data RDW when i==1.
  bit [7:0] mem_m [2][DEPTH];
  int       busy_left [2] = '{DEPTH, DEPTH};
  bit       due_v [2][4];
  bit [7:0] due_d [2][4];
  bit [7:0] qm [2];
  bit       qvm [2];
  int       n = 0;

  task automatic model_edge(input int i);
    int s;
    bit [7:0] v;
    s = n % 4;
    if (rst) begin
      busy_left[i] = DEPTH;
      for (int k = 0; k < 4; k++) due_v[i][k] = 1'b0;
      qm[i] = 8'h00;
      qvm[i] = 1'b0;
      return;
    end
    qvm[i] = 1'b0;
    if (busy_left[i] == 0) begin
      if (rden) begin
        v = (i == 1 && wren && wa == ra) ? wd : mem_m[i][ra];
        due_v[i][(n + i) % 4] = 1'b1;
        due_d[i][(n + i) % 4] = v;
      end
      if (wren) mem_m[i][wa] = wd;
    end else begin
      busy_left[i]--;
      // Requests are locked out during the clear, so the whole array is
      // INIT once the countdown expires.
      if (busy_left[i] == 0)
        for (int a = 0; a < DEPTH; a++) mem_m[i][a] = INIT;
    end
    if (due_v[i][s]) begin
      qvm[i] = 1'b1;
      qm[i] = due_d[i][s];
      due_v[i][s] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, n);
    end
  endtask

  // Apply one cycle of inputs, advance one edge, then compare both
  // instances against the model 1ns after the edge.
  task automatic step(input bit r, input bit we, input logic [7:0] a_w, input logic [7:0] d,
                      input bit re, input logic [7:0] a_r);
    rst = r; wren = we; wa = a_w; wd = d; rden = re; ra = a_r;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    n++;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(busy_left[i] > 0));
      chk($sformatf("q_valid%0d", i), 32'(qv_w[i]), 32'(qvm[i]));
      chk($sformatf("q%0d", i), 32'(q_w[i]), 32'(qm[i]));
    end
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 8'h00, 0, 8'h00);
  endtask

  // Reset pulse, then wait out the clear while counting busy cycles.
  // With lock set, the first clear cycles attempt a write and a read.
  task automatic run_clear(input bit lock);
    int cnt;
    cnt = 0;
    step(1, 0, 8'h00, 8'h00, 0, 8'h00);
    for (int k = 0; k < 300; k++) begin
      if (!busy_w[0]) break;
      cnt++;
      if (lock && k < 20) step(0, 1, 8'hFF, 8'h77, 1, 8'hFF);
      else idle();
    end
    chk("busy_len", 32'(cnt), 32'(DEPTH));
  endtask

  task automatic rd_exp(input logic [7:0] a, input logic [7:0] v);
    step(0, 0, 8'h00, 8'h00, 1, a);
    chk("rd_q_lat1", 32'(q_w[0]), 32'(v));
    chk("rd_v_lat1", 32'(qv_w[0]), 32'd1);
    chk("rd_v_lat2_early", 32'(qv_w[1]), 32'd0);
    idle();
    chk("rd_q_lat2", 32'(q_w[1]), 32'(v));
    chk("rd_v_lat2", 32'(qv_w[1]), 32'd1);
    chk("rd_v_lat1_drop", 32'(qv_w[0]), 32'd0);
  endtask

  initial begin
    logic [7:0] e;
    rst = 1'b1; wren = 1'b0; rden = 1'b0; wa = '0; wd = '0; ra = '0;

    // Clear with busy lockout, then check the cleared contents.
    run_clear(1'b1);
    rd_exp(8'h00, INIT);
    rd_exp(8'h7F, INIT);
    rd_exp(8'hFF, INIT);

    // Write then read.
    step(0, 1, 8'h10, 8'h3C, 0, 8'h00);
    rd_exp(8'h10, 8'h3C);
    idle();

    // Back-to-back streaming reads.
    for (int k = 0; k < 4; k++) step(0, 1, 8'(k), 8'(8'h11 * (k + 1)), 0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) step(0, 0, 8'h00, 8'h00, 1, 8'(k));
      else idle();
      if (k >= 1) begin
        e = 8'(8'h11 * k);
        chk("stream_q_lat2", 32'(q_w[1]), 32'(e));
        chk("stream_v_lat2", 32'(qv_w[1]), 32'd1);
      end
    end
    idle();
    chk("stream_v_lat2_end", 32'(qv_w[1]), 32'd0);

    // Read-during-write at the same address.
    step(0, 1, 8'h20, 8'h55, 0, 8'h00);
    step(0, 1, 8'h20, 8'hAA, 1, 8'h20);
    chk("rdw_old", 32'(q_w[0]), 32'h55);
    step(0, 0, 8'h00, 8'h00, 1, 8'h20);
    chk("rdw_after_old", 32'(q_w[0]), 32'hAA);
    chk("rdw_new", 32'(q_w[1]), 32'hAA);
    idle();
    chk("rdw_after_new", 32'(q_w[1]), 32'hAA);
    idle();

    // Random traffic; narrow address ranges force write/read collisions.
    for (int k = 0; k < 400; k++) begin
      logic [7:0] a1, a2;
      a1 = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 8);
      a2 = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 8);
      step(0, 1'($urandom), a1, 8'($urandom), 1'($urandom), a2);
    end
    idle(); idle();

    // Reset with a latency-2 read in flight.
    step(0, 1, 8'h10, 8'h3C, 0, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 8'h10);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00);
    chk("rst_flush_v", 32'(qv_w[1]), 32'd0);
    chk("rst_flush_q", 32'(q_w[1]), 32'd0);
    chk("rst_busy", 32'(busy_w[1]), 32'd1);
    run_clear(1'b0);
    rd_exp(8'h10, INIT);
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
